// File: rtl/bch_enc_seq_if.sv
// Handshake bundle for the BCH(41,31) bit-serial encoder: message in, codeword out.
interface bch_enc_seq_if #(
   parameter int unsigned K = 31,
   parameter int unsigned P = 10
);
   logic             in_valid;
   logic             in_ready;
   logic [K-1:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [K+P-1:0]   out_data;

   // Encoder side
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   // Source/sink side
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/bch_enc_seq.sv
// Bit-serial BCH(41,31) systematic encoder. The message is shifted MSB-first through a
// P-bit LFSR divider; the remainder is (msg(x) * x^P) mod g(x), emitted as {msg, parity}.
module bch_enc_seq #(
   parameter int unsigned K   = 31,
   parameter int unsigned P   = 10,
   parameter logic [P:0]  GEN = 11'h769
) (
   input  logic          clk,
   input  logic          rst,
   bch_enc_seq_if.slave  bus,
   output logic          busy,
   output logic [15:0]   word_cnt
);
   localparam int unsigned N  = K + P;
   localparam int unsigned CW = $clog2(K);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [P-1:0]    r_lfsr;
   logic [CW-1:0]   r_cnt;
   logic [K-1:0]    r_msg;
   logic [K-1:0]    r_shreg;
   logic [N-1:0]    r_out;
   logic [15:0]     r_word_cnt;

   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_busy;
   logic            w_accept;
   logic            w_deliver;
   logic            w_fb;
   logic [P-1:0]    w_lfsr_next;

   // Next-state decode and handshake outputs
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_busy       = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_next = StShift;
         end
         StShift: begin
            w_busy = 1'b1;
            if (r_cnt == '0) w_state_next = StDone;
         end
         StDone: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               // Releasing the codeword frees the slot, so a new word may enter this same cycle
               w_in_ready   = 1'b1;
               w_state_next = bus.in_valid ? StShift : StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // LFSR divider step: feedback is incoming message bit plus remainder MSB
   always_comb begin
      w_fb        = r_shreg[K-1] ^ r_lfsr[P-1];
      w_lfsr_next = {r_lfsr[P-2:0], 1'b0} ^ (w_fb ? GEN[P-1:0] : '0);
      w_accept    = w_in_ready & bus.in_valid;
      w_deliver   = w_out_valid & bus.out_ready;
   end

   // State, datapath and delivered-word counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_lfsr     <= '0;
         r_cnt      <= '0;
         r_msg      <= '0;
         r_shreg    <= '0;
         r_out      <= '0;
         r_word_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_msg   <= bus.in_data;
            r_shreg <= bus.in_data;
            r_lfsr  <= '0;
            r_cnt   <= CW'(K - 1);
         end else if (r_state == StShift) begin
            r_lfsr  <= w_lfsr_next;
            r_shreg <= {r_shreg[K-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
            // Capture the finished codeword so it stays put even if the next word starts early
            if (r_cnt == '0) r_out <= {r_msg, w_lfsr_next};
         end
         if (w_deliver) r_word_cnt <= r_word_cnt + 16'd1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_out;
   assign busy          = w_busy;
   assign word_cnt      = r_word_cnt;
endmodule

// File: tb/tb_bch_enc_seq.sv
// Self-checking bench for bch_enc_seq against a polynomial long-division reference.
module tb_bch_enc_seq;
   localparam int unsigned K = 31;
   localparam int unsigned P = 10;
   localparam int unsigned N = K + P;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] word_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   bch_enc_seq_if #(.K(K), .P(P)) bus ();

   bch_enc_seq #(.K(K), .P(P), .GEN(11'h769)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // Reference: GF(2) long division of msg(x)*x^10 by g(x)
   function automatic logic [P-1:0] ref_par(input logic [K-1:0] m);
      logic [N-1:0] v;
      logic [N-1:0] g;
      v = {m, {P{1'b0}}};
      g = 41'h769;
      for (int i = N - 1; i >= int'(P); i--)
         if (v[i]) v = v ^ (g << (i - int'(P)));
      return v[P-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a message and hold it until the accepting edge has passed
   task automatic send(input logic [K-1:0] m);
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = m;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("send_timeout", 64'(n), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = K'($urandom);
   endtask

   // Edges from the accept edge until out_valid is seen; bounded
   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int            lat;
      int            seen;
      logic [K-1:0]  m;
      logic [K-1:0]  pend_msg;
      logic          pend;
      logic [P-1:0]  par_obs [10];
      logic [N-1:0]  held;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // 1: reset state
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);

      // 2: known vectors, accept edge to out_valid is K edges (K+1 cycles counting accept)
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m = K'(i);
         send(m);
         wait_valid(lat);
         check("vec_latency", 64'(lat), 64'(K));
         check("vec_busy_done", 64'(busy), 64'd0);
         check("vec_data", 64'(bus.out_data), 64'({m, ref_par(m)}));
         tick();
         check("vec_word_cnt", 64'(word_cnt), 64'(i + 1));
      end
      check("vec_par1_const", 64'(ref_par(31'd1)), 64'h369);
      check("vec_par3_const", 64'(ref_par(31'd3)), 64'h2D2);

      // 3: back-pressure holds the codeword
      bus.out_ready = 1'b0;
      send(31'd1);
      wait_valid(lat);
      check("stall_latency", 64'(lat), 64'(K));
      for (int j = 0; j < 10; j++) begin
         check("stall_valid", 64'(bus.out_valid), 64'd1);
         check("stall_data", 64'(bus.out_data), 64'({31'd1, 10'h369}));
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_word_cnt", 64'(word_cnt), 64'd4);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("stall_release_cnt", 64'(word_cnt), 64'd5);
      check("stall_release_valid", 64'(bus.out_valid), 64'd0);

      // 4: back-to-back stream 0..9
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = '0;
      tick();
      for (int i = 0; i < 10; i++) begin
         wait_valid(lat);
         check("b2b_latency", 64'(lat), 64'(K));
         check("b2b_data", 64'(bus.out_data), 64'({K'(i), ref_par(K'(i))}));
         par_obs[i] = bus.out_data[P-1:0];
         if (i > 0)
            check("b2b_linear", 64'(par_obs[i] ^ par_obs[i-1]), 64'(ref_par(K'(i ^ (i - 1)))));
         check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
         if (i < 9) bus.in_data = K'(i + 1);
         else bus.in_valid = 1'b0;
         tick();
         if (i < 9) check("b2b_no_gap", 64'(busy), 64'd1);
      end
      check("b2b_word_cnt", 64'(word_cnt), 64'd10);

      // 5: reset mid-shift discards the word
      send(K'($urandom));
      for (int j = 0; j < 15; j++) tick();
      check("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
      seen = 0;
      for (int j = 0; j < 40; j++) begin
         if (bus.out_valid) seen++;
         tick();
      end
      check("mid_no_out", 64'(seen), 64'd0);
      send(31'd2);
      wait_valid(lat);
      check("mid_next_data", 64'(bus.out_data), 64'({31'd2, 10'h1BB}));
      tick();

      // 6: random words, random stalls, random overlapped accepts
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b0;
      pend = 1'b0;
      pend_msg = '0;
      for (int w = 0; w < 1000; w++) begin
         if (pend) m = pend_msg;
         else begin
            m = K'($urandom);
            send(m);
         end
         wait_valid(lat);
         check("rnd_valid", 64'(bus.out_valid), 64'd1);
         held = {m, ref_par(m)};
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
         check("rnd_data", 64'(bus.out_data), 64'(held));
         bus.out_ready = 1'b1;
         pend = 1'b0;
         if (w < 999 && $urandom_range(0, 1) == 1) begin
            pend         = 1'b1;
            pend_msg     = K'($urandom);
            bus.in_valid = 1'b1;
            bus.in_data  = pend_msg;
         end
         tick();
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b0;
      end
      check("rnd_word_cnt", 64'(word_cnt), 64'd1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
